// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Round-robin arbiter that shares one UART transmit line between two byte
//   requesters. The granted byte is sent as start / data (LSB first) / [parity]
//   / stop bits. Each bit level changes only on a txclk_en tick.
//
//   Optional feature macro: UART_TX_PARITY_EN
//     defined   -> even parity bit after the data bits
//     undefined -> no parity state and no parity logic
//
//   Ports
//     clk_i         system clock
//     rst_i         asynchronous active-high reset
//     txclk_en_i    one-cycle bit-period tick
//     req0_valid_i  requester 0 has a byte
//     req0_data_i   requester 0 byte (low DATA_BITS used)
//     req0_ready_o  requester 0 byte accepted when valid & ready
//     req1_valid_i  requester 1 has a byte
//     req1_data_i   requester 1 byte (low DATA_BITS used)
//     req1_ready_o  requester 1 byte accepted when valid & ready
//     tx_o          serial line, idle high
//     busy_o        frame in progress (acceptance to frame end)
//     grant_id_o    requester owning the current / last frame
//
//   state      | meaning
//   S_IDLE     | line idle, arbitration and handshake
//   S_WAIT_ST  | byte latched, next tick drives the start bit
//   S_DATA     | next tick drives the next data bit
//   S_PARITY   | next tick drives the parity bit (parity build only)
//   S_STOP     | stop level driven, counting stop periods
module uart_tx_arbiter #(
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       txclk_en_i,
  input  logic       req0_valid_i,
  input  logic [7:0] req0_data_i,
  output logic       req0_ready_o,
  input  logic       req1_valid_i,
  input  logic [7:0] req1_data_i,
  output logic       req1_ready_o,
  output logic       tx_o,
  output logic       busy_o,
  output logic       grant_id_o
);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_ST, S_DATA, S_PARITY, S_STOP
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_ST, S_DATA, S_STOP
  } state_t;
`endif

  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS);

  state_t                 state_q, state_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   tx_q, tx_d;
  logic                   busy_q, busy_d;
  logic                   grant_q, grant_d;
  logic                   last_q, last_d;
`ifdef UART_TX_PARITY_EN
  logic                   parity_q, parity_d;
`endif

  logic sel_id;
  logic any_valid;
  logic in_idle;

  // Round-robin pick: a lone requester wins outright; on contention the
  // requester that did not own the last frame wins.
  always_comb begin
    any_valid = req0_valid_i | req1_valid_i;
    if (req0_valid_i && req1_valid_i) sel_id = ~last_q;
    else                              sel_id = req1_valid_i;
  end

  // Ready is gated by rst_i so nothing is offered while reset is held.
  assign in_idle      = (state_q == S_IDLE) && !rst_i;
  assign req0_ready_o = in_idle & req0_valid_i & ~sel_id;
  assign req1_ready_o = in_idle & req1_valid_i &  sel_id;

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    tx_d     = tx_q;
    busy_d   = busy_q;
    grant_d  = grant_q;
    last_d   = last_q;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        // A tick in the handshake cycle is deliberately ignored: the start
        // bit waits for the first tick strictly after acceptance.
        if (any_valid) begin
          shift_d = sel_id ? req1_data_i[DATA_BITS-1:0] : req0_data_i[DATA_BITS-1:0];
          grant_d = sel_id;
          last_d  = sel_id;
          busy_d  = 1'b1;
          state_d = S_WAIT_ST;
        end
      end
      S_WAIT_ST: begin
        if (txclk_en_i) begin
          tx_d     = 1'b0;
          cnt_d    = 4'd0;
          state_d  = S_DATA;
`ifdef UART_TX_PARITY_EN
          parity_d = 1'b0;
`endif
        end
      end
      S_DATA: begin
        if (txclk_en_i) begin
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
`ifdef UART_TX_PARITY_EN
          parity_d = parity_q ^ shift_q[0];
`endif
          if (cnt_q == LAST_DATA) begin
            cnt_d = 4'd0;
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (txclk_en_i) begin
          tx_d    = parity_q;
          cnt_d   = 4'd0;
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        // First tick raises the line; each further tick closes one stop
        // period, and the tick closing the last one returns to idle.
        if (txclk_en_i) begin
          tx_d = 1'b1;
          if (cnt_q == LAST_STOP) begin
            busy_d  = 1'b0;
            cnt_d   = 4'd0;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      shift_q  <= '0;
      cnt_q    <= 4'd0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      grant_q  <= 1'b0;
      last_q   <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign tx_o       = tx_q;
  assign busy_o     = busy_q;
  assign grant_id_o = grant_q;

endmodule
